// File: rtl/rd_ptr_empty.sv
// Read-side pointer/empty generator for the async FIFO; optional almost_empty via RD_ALMOST_EMPTY_EN.
// Latency: a read advances the pointers on the same edge. A write shows as !empty SYNC_STAGES+1 edges after g_wptr moves.
// Backpressure: reads are accepted only while !empty. A read while empty is dropped without error.
module rd_ptr_empty #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              r_en,
  input  logic [ADDR_W:0]   g_wptr,
  output logic [ADDR_W:0]   b_rptr,
  output logic [ADDR_W:0]   g_rptr,
  output logic [ADDR_W-1:0] r_addr,
  output logic              empty,
  output logic [ADDR_W:0]   rd_level
`ifdef RD_ALMOST_EMPTY_EN
  ,
  output logic              almost_empty
`endif
);

  localparam int PTR_W = ADDR_W + 1;

  // Reject synchronizer depths outside 2..4 and negative thresholds at elaboration.
  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4) || (AE_THRESH < 0)) begin : g_bad_param
    $error("rd_ptr_empty: SYNC_STAGES must be 2..4 and AE_THRESH >= 0");
  end

  logic [PTR_W-1:0] sync_q [SYNC_STAGES];
  logic [PTR_W-1:0] g_wptr_s;
  logic [PTR_W-1:0] b_wptr_s;
  logic             rd_fire;
  logic [PTR_W-1:0] b_rptr_nxt;
  logic [PTR_W-1:0] g_rptr_nxt;
  logic [PTR_W-1:0] level_nxt;

  // Plain flop chain bringing the write Gray pointer into rclk; no logic between stages.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= g_wptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign g_wptr_s = sync_q[SYNC_STAGES-1];

  // Gray-to-binary conversion of the synchronized write pointer, XOR prefix from the MSB down.
  always_comb begin
    b_wptr_s         = '0;
    b_wptr_s[ADDR_W] = g_wptr_s[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b_wptr_s[i] = b_wptr_s[i+1] ^ g_wptr_s[i];
    end
  end

  assign rd_fire    = r_en && !empty;
  assign b_rptr_nxt = b_rptr + {{ADDR_W{1'b0}}, rd_fire};
  assign g_rptr_nxt = b_rptr_nxt ^ (b_rptr_nxt >> 1);
  // Modulo subtraction; the wrap bit makes a completely full FIFO read as 2**ADDR_W rather than 0.
  assign level_nxt  = b_wptr_s - b_rptr_nxt;

  // Pointers, empty and level update together, so empty rises on the edge that consumes the last entry.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      b_rptr   <= '0;
      g_rptr   <= '0;
      empty    <= 1'b1;
      rd_level <= '0;
    end else begin
      b_rptr   <= b_rptr_nxt;
      g_rptr   <= g_rptr_nxt;
      empty    <= (g_rptr_nxt == g_wptr_s);
      rd_level <= level_nxt;
    end
  end

  assign r_addr = b_rptr[ADDR_W-1:0];

`ifdef RD_ALMOST_EMPTY_EN
  localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_THRESH);

  // Almost-empty is registered from the same next-level value, so it stays aligned with rd_level.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      almost_empty <= 1'b1;
    end else begin
      almost_empty <= (level_nxt <= AE_LVL);
    end
  end
`endif

endmodule

// File: doc/rd_ptr_empty.md
Name: rd_ptr_empty

Overview:
Read-domain pointer and empty-flag generator for the asynchronous FIFO, counterpart to the write-side pointer block. It synchronizes the write-domain Gray pointer into rclk and advances the binary/Gray read pointer on accepted reads. It produces the registered empty flag, the RAM read address, and the Gray read pointer that the write side synchronizes for its full check.

Parameters:
ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W; pointers are ADDR_W+1 bits (MSB = wrap bit)
SYNC_STAGES, 2, number of flops in the g_wptr synchronizer chain; legal range 2..4
AE_THRESH, 2, almost-empty threshold in entries (used only with RD_ALMOST_EMPTY_EN)

Ports:
rclk  input  1  read-domain clock
rrst_n  input  1  asynchronous active-low reset, read domain
r_en  input  1  read request from consumer
g_wptr  input  ADDR_W+1  Gray write pointer, launched from the wclk domain, unsynchronized
b_rptr  output  ADDR_W+1  binary read pointer, registered
g_rptr  output  ADDR_W+1  Gray read pointer, registered, sent to the write domain
r_addr  output  ADDR_W  RAM read address = b_rptr[ADDR_W-1:0]
empty  output  1  registered empty flag
rd_level  output  ADDR_W+1  registered entries available to read, 0..2**ADDR_W
almost_empty  output  1  present only with RD_ALMOST_EMPTY_EN

Behaviour:
- Reset: asynchronous on rrst_n low. b_rptr=0, g_rptr=0, all sync flops=0, empty=1, rd_level=0, almost_empty=1. Release is taken on the next rclk edge.
- Synchronizer: g_wptr passes through SYNC_STAGES flops, giving g_wptr_s. No logic sits between the flops. b_wptr_s = gray-to-binary(g_wptr_s), computed as an XOR prefix from the MSB down.
- Accept: rd_fire = r_en && !empty. A read while empty is ignored: no pointer change and no error.
- Next pointer: b_rptr_nxt = b_rptr + rd_fire, modulo 2**(ADDR_W+1). Natural wrap: all-ones returns to 0 and the wrap bit toggles.
- Gray next pointer: g_rptr_nxt = b_rptr_nxt ^ (b_rptr_nxt >> 1). b_rptr and g_rptr register together every rclk edge, so exactly one Gray bit changes per read.
- Empty: empty <= (g_rptr_nxt == g_wptr_s), a full-width compare that includes the wrap bit. It is registered, so empty asserts in the same edge that consumes the last entry.
- Latency: a write becomes visible as empty deasserting SYNC_STAGES+1 rclk edges after g_wptr changes.
- Level: rd_level <= (b_wptr_s - b_rptr_nxt) mod 2**(ADDR_W+1). rd_level is conservative, since the write pointer lags by the synchronizer depth.
- Simultaneous read and newly synchronized write on the same edge: the pointer advances, and empty/rd_level reflect both events.
- Reset mid-operation: all state clears immediately and empty=1 regardless of r_en. The write side must also be reset; there is no cross-domain reset handshake in this block.
- No read-side overflow is possible: rd_level never exceeds 2**ADDR_W when the write side respects full.

Optional Feature:
RD_ALMOST_EMPTY_EN:
- Defined: the almost_empty port exists. almost_empty <= (next rd_level <= AE_THRESH), registered, with reset value 1. It is registered in the same edge as empty.
- Undefined: the almost_empty port and its logic are absent. All other behaviour is identical.

Test Plan:
Use ADDR_W=4 and SYNC_STAGES=2 for all scenarios.
- Reset: hold rrst_n=0 with r_en=1 and g_wptr toggling -> b_rptr=0, g_rptr=0, empty=1, rd_level=0. Assert rrst_n=0 asynchronously mid-cycle -> outputs clear before the next rclk edge.
- Empty exit latency: g_wptr changes 0 -> 1 (gray 00001) -> empty falls exactly 3 rclk edges later and rd_level=1. r_en=1 for one cycle -> b_rptr=1, g_rptr=00001, empty=1.
- Read while empty: g_wptr=0, r_en held 1 for 10 cycles -> b_rptr stays 0 and empty stays 1.
- Full drain and wrap: g_wptr=gray(16)=11000 with b_rptr=0 -> rd_level=16. Issue 16 reads -> b_rptr=16 (10000), r_addr=0, g_rptr=11000, empty=1. Continue to b_rptr=31 -> 0 -> g_rptr steps 10000 -> 00000, with a single-bit change verified every step.
- Simultaneous events: rd_level=1, read issued on the same edge that the synchronized g_wptr advances by 1 -> empty stays 0 and rd_level stays 1.
- With RD_ALMOST_EMPTY_EN and AE_THRESH=2: rd_level 4 -> 3 -> 2 -> almost_empty rises together with rd_level=2. Refill to 3 -> almost_empty=0.
